// File: rtl/flu_field_align_pkg.sv
// Shared widths and the FLU word type for the field-align block.
// Defaults match the 512-bit FLU datapath and the 32-bit extractor output.
package flu_align_pkg;

    localparam int DATA_W         = 512;
    localparam int SOP_POS_W      = 3;
    localparam int EOP_POS_W      = $clog2(DATA_W / 8);
    localparam int FIELD_W        = 32;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH_DEF) + 1;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [SOP_POS_W-1:0] sop_pos;
        logic [EOP_POS_W-1:0] eop_pos;
        logic                 sop;
        logic                 eop;
    } flu_word_t;

endpackage

// File: rtl/flu_field_align_if.sv
// RX packet, HDR field and TX packet streams of the field aligner, plus status.
// master = upstream extractor / downstream sink side, slave = the aligner.
interface flu_field_align_if
    import flu_align_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int SOP_POS_WIDTH = SOP_POS_W,
    parameter int EOP_POS_WIDTH = EOP_POS_W,
    parameter int FIELD_WIDTH   = FIELD_W,
    parameter int CNT_WIDTH     = FIFO_CNT_WIDTH
);
    logic [DATA_WIDTH-1:0]    rx_data;
    logic [SOP_POS_WIDTH-1:0] rx_sop_pos;
    logic [EOP_POS_WIDTH-1:0] rx_eop_pos;
    logic                     rx_sop;
    logic                     rx_eop;
    logic                     rx_src_rdy;
    logic                     rx_dst_rdy;

    logic [FIELD_WIDTH-1:0]   hdr_data;
    logic                     hdr_sop;
    logic                     hdr_eop;
    logic                     hdr_src_rdy;
    logic                     hdr_dst_rdy;

    logic [DATA_WIDTH-1:0]    tx_data;
    logic [SOP_POS_WIDTH-1:0] tx_sop_pos;
    logic [EOP_POS_WIDTH-1:0] tx_eop_pos;
    logic                     tx_sop;
    logic                     tx_eop;
    logic [FIELD_WIDTH-1:0]   tx_field;
    logic                     tx_src_rdy;
    logic                     tx_dst_rdy;

    logic [CNT_WIDTH-1:0]     fifo_cnt;
    logic                     hdr_err;

    modport slave (
        input  rx_data, rx_sop_pos, rx_eop_pos, rx_sop, rx_eop, rx_src_rdy,
        output rx_dst_rdy,
        input  hdr_data, hdr_sop, hdr_eop, hdr_src_rdy,
        output hdr_dst_rdy,
        output tx_data, tx_sop_pos, tx_eop_pos, tx_sop, tx_eop, tx_field, tx_src_rdy,
        input  tx_dst_rdy,
        output fifo_cnt, hdr_err
    );

    modport master (
        output rx_data, rx_sop_pos, rx_eop_pos, rx_sop, rx_eop, rx_src_rdy,
        input  rx_dst_rdy,
        output hdr_data, hdr_sop, hdr_eop, hdr_src_rdy,
        input  hdr_dst_rdy,
        input  tx_data, tx_sop_pos, tx_eop_pos, tx_sop, tx_eop, tx_field, tx_src_rdy,
        output tx_dst_rdy,
        input  fifo_cnt, hdr_err
    );

endinterface

// File: rtl/flu_field_align_fifo.sv
// Field FIFO, first-word-fall-through: head valid whenever !empty, 1-cycle push-to-visible.
// Backpressure: full blocks push, empty blocks pop; illegal requests are ignored.
module field_align_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flu_field_align.sv
// Attaches the buffered extracted field to each FLU SOP word; RX->TX latency 1 cycle.
// Backpressure: TX stall holds the output register; SOP words stall until a field is buffered.
module flu_field_align
    import flu_align_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int SOP_POS_WIDTH = SOP_POS_W,
    parameter int EOP_POS_WIDTH = $clog2(DATA_WIDTH / 8),
    parameter int FIELD_WIDTH   = FIELD_W,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    flu_field_align_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                   out_free;
    logic                   rx_xfer;
    logic                   hdr_xfer;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIELD_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]       fifo_count;

    assign out_free        = !bus.tx_src_rdy || bus.tx_dst_rdy;
    assign bus.rx_dst_rdy  = out_free && (!bus.rx_sop || !fifo_empty);
    assign bus.hdr_dst_rdy = !fifo_full;
    assign rx_xfer         = bus.rx_src_rdy && bus.rx_dst_rdy;
    assign hdr_xfer        = bus.hdr_src_rdy && bus.hdr_dst_rdy;
    // A word with EOP(A)+SOP(B) still pops once: only B's field belongs to it.
    assign pop             = rx_xfer && bus.rx_sop;
    assign bus.fifo_cnt    = fifo_count;

    field_align_fifo #(
        .WIDTH (FIELD_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hdr_xfer),
        .push_data (bus.hdr_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.tx_src_rdy <= 1'b0;
            bus.tx_data    <= '0;
            bus.tx_sop_pos <= '0;
            bus.tx_eop_pos <= '0;
            bus.tx_sop     <= 1'b0;
            bus.tx_eop     <= 1'b0;
            bus.tx_field   <= '0;
        end else if (out_free) begin
            bus.tx_src_rdy <= rx_xfer;
            if (rx_xfer) begin
                bus.tx_data    <= bus.rx_data;
                bus.tx_sop_pos <= bus.rx_sop_pos;
                bus.tx_eop_pos <= bus.rx_eop_pos;
                bus.tx_sop     <= bus.rx_sop;
                bus.tx_eop     <= bus.rx_eop;
                bus.tx_field   <= bus.rx_sop ? fifo_head : '0;
            end
        end
    end

    // Malformed frames are still pushed so fields stay one-per-packet aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.hdr_err <= 1'b0;
        end else if (hdr_xfer && !(bus.hdr_sop && bus.hdr_eop)) begin
            bus.hdr_err <= 1'b1;
        end
    end

endmodule
